// File: rtl/tdc_pfd_lock.sv
// rtl/tdc_pfd_lock.sv - sequential PFD/TDC with cycle-slip and lock detection
//
// Samples clk_ref and fb_clk in the clk domain, measures the separation of
// each ref/fb rising-edge pair as a saturating count of clk cycles, and emits
// a signed phase error (positive = ref leads) for the digital loop filter.
//
// Ports:
//   clk        system sampling clock, rising edge
//   reset_n    asynchronous active-low reset
//   clk_ref    reference clock, asynchronous to clk
//   fb_clk     DCO feedback clock, asynchronous to clk
//   up         high while the FSM is in LEAD (ref edge seen, waiting for fb)
//   dwn        high while the FSM is in LAG  (fb edge seen, waiting for ref)
//   err        signed two's-complement phase error, holds between strobes
//   err_valid  one-cycle strobe marking a new err value
//   slip       one-cycle strobe, second same-side edge before the other side
//   locked     lock indicator
module tdc_pfd_lock #(
    parameter int CNT_W       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_TOL    = 1,
    parameter int LOCK_CNT    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_ref,
    input  logic             fb_clk,
    output logic             up,
    output logic             dwn,
    output logic [CNT_W:0]   err,
    output logic             err_valid,
    output logic             slip,
    output logic             locked
);

    localparam int                LC_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  MAX    = '1;
    localparam logic [CNT_W-1:0]  TOL    = CNT_W'(LOCK_TOL);
    localparam logic [LC_W-1:0]   LC_MAX = LC_W'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, LEAD, LAG} state_t;

    logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic [SYNC_STAGES-1:0] fb_sync_q, fb_sync_d;
    logic                   ref_dly_q, ref_dly_d;
    logic                   fb_dly_q, fb_dly_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W:0]         err_q, err_d;
    logic                   err_valid_q, err_valid_d;
    logic                   slip_q, slip_d;
    logic [LC_W-1:0]        lock_cnt_q, lock_cnt_d;
    logic                   locked_q, locked_d;

    logic                   s_ref, s_fb, ref_rise, fb_rise;
    logic                   emit, neg, in_tol;
    logic [CNT_W-1:0]       mag, cnt_inc;
    logic [CNT_W:0]         mag_ext;

    assign s_ref    = ref_sync_q[SYNC_STAGES-1];
    assign s_fb     = fb_sync_q[SYNC_STAGES-1];
    assign ref_rise = s_ref & ~ref_dly_q;
    // fb edges are ignored until the first ref edge; a fb edge coincident
    // with the arming ref edge is paired with it.
    assign fb_rise  = s_fb & ~fb_dly_q & (armed_q | ref_rise);
    assign cnt_inc  = (cnt_q == MAX) ? MAX : cnt_q + 1'b1;

    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], clk_ref};
        fb_sync_d  = {fb_sync_q[SYNC_STAGES-2:0], fb_clk};
        ref_dly_d  = s_ref;
        fb_dly_d   = s_fb;
        armed_d    = armed_q | ref_rise;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        emit    = 1'b0;
        neg     = 1'b0;
        mag     = '0;
        slip_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    emit = 1'b1;
                end else if (ref_rise) begin
                    state_d = LEAD;
                    cnt_d   = 1;
                end else if (fb_rise) begin
                    state_d = LAG;
                    cnt_d   = 1;
                end
            end
            LEAD: begin
                if (fb_rise && !ref_rise) begin
                    emit    = 1'b1;
                    mag     = cnt_q;
                    state_d = IDLE;
                end else if (ref_rise && !fb_rise) begin
                    emit   = 1'b1;
                    mag    = MAX;
                    slip_d = 1'b1;
                    cnt_d  = 1;
                end else if (ref_rise && fb_rise) begin
                    emit  = 1'b1;
                    mag   = cnt_q;
                    cnt_d = 1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            LAG: begin
                neg = 1'b1;
                if (ref_rise && !fb_rise) begin
                    emit    = 1'b1;
                    mag     = cnt_q;
                    state_d = IDLE;
                end else if (fb_rise && !ref_rise) begin
                    emit   = 1'b1;
                    mag    = MAX;
                    slip_d = 1'b1;
                    cnt_d  = 1;
                end else if (ref_rise && fb_rise) begin
                    emit  = 1'b1;
                    mag   = cnt_q;
                    cnt_d = 1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign mag_ext = {1'b0, mag};

    always_comb begin
        err_valid_d = emit;
        err_d       = err_q;
        if (emit) begin
            err_d = neg ? -mag_ext : mag_ext;
        end
    end

    // Lock tracking runs off the pre-register emit so that an out-of-tolerance
    // measurement clears locked on the same edge that raises err_valid.
    assign in_tol = (mag <= TOL) & ~slip_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (emit && in_tol) begin
            lock_cnt_d = (lock_cnt_q == LC_MAX) ? LC_MAX : lock_cnt_q + 1'b1;
        end
        if (emit && !in_tol) begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (lock_cnt_q == LC_MAX) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ref_sync_q  <= '0;
            fb_sync_q   <= '0;
            ref_dly_q   <= 1'b0;
            fb_dly_q    <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            slip_q      <= 1'b0;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            ref_sync_q  <= ref_sync_d;
            fb_sync_q   <= fb_sync_d;
            ref_dly_q   <= ref_dly_d;
            fb_dly_q    <= fb_dly_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            slip_q      <= slip_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign up        = (state_q == LEAD);
    assign dwn       = (state_q == LAG);
    assign err       = err_q;
    assign err_valid = err_valid_q;
    assign slip      = slip_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_tdc_pfd_lock.sv
// tb/tb_tdc_pfd_lock.sv - self-checking bench for tdc_pfd_lock
module tb_tdc_pfd_lock;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_ref = 1'b0;
    logic       fb_clk = 1'b0;
    logic       up, dwn, err_valid, slip, locked;
    logic [5:0] err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tdc_pfd_lock #(.CNT_W(5), .SYNC_STAGES(2), .LOCK_TOL(1), .LOCK_CNT(16)) dut (
        .clk(clk), .reset_n(reset_n), .clk_ref(clk_ref), .fb_clk(fb_clk),
        .up(up), .dwn(dwn), .err(err), .err_valid(err_valid),
        .slip(slip), .locked(locked)
    );

    typedef struct {
        int ref_off; int fb_off; int per; int n;
        bit ref_en; bit fb_en; bit pre;
        int exp_n; int exp_err; bit exp_slip; int exp_up; int exp_dwn;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit wave(input int c, input int off, input int per, input int n);
        int k;
        k = c - off;
        return (k >= 0) && (k < n * per) && ((k % per) < per / 2);
    endfunction

    // Arming pair: ref edge at cycle 2, fb edge 5 cycles later (err=+5, out of tolerance).
    function automatic bit pre_ref(input int c);
        return (c >= 2) && (c < 10);
    endfunction
    function automatic bit pre_fb(input int c);
        return (c >= 7) && (c < 14);
    endfunction

    task automatic tick(input bit r, input bit f);
        @(negedge clk);
        clk_ref = r;
        fb_clk  = f;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clk_ref = 1'b0;
        fb_clk  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int nstr, nup, ndwn, nstray, len, got, uprun, nlock;
        bit r, f, seen16;

        //           ref fb  per  n  ren fen pre  exp_n err  slip up   dwn
        vecs[0]  = '{0,  4,  64,  4, 0,  1,  0,   0,    0,   0,   0,   0};
        vecs[1]  = '{20, 27, 64,  4, 1,  1,  1,   4,    7,   0,   28,  0};
        vecs[2]  = '{32, 20, 64,  4, 1,  1,  1,   4,    -12, 0,   0,   48};
        vecs[3]  = '{20, 0,  80,  4, 1,  0,  1,   3,    31,  1,   -1,  0};
        vecs[4]  = '{20, 60, 100, 3, 1,  1,  1,   3,    31,  0,   120, 0};
        vecs[5]  = '{20, 51, 100, 3, 1,  1,  1,   3,    31,  0,   93,  0};
        vecs[6]  = '{20, 50, 100, 3, 1,  1,  1,   3,    30,  0,   90,  0};
        vecs[7]  = '{20, 20, 64,  4, 1,  1,  1,   4,    0,   0,   0,   0};
        vecs[8]  = '{20, 21, 64,  4, 1,  1,  1,   4,    1,   0,   4,   0};
        vecs[9]  = '{60, 20, 100, 3, 1,  1,  1,   3,    -31, 0,   0,   120};
        vecs[10] = '{0,  20, 80,  4, 0,  1,  1,   3,    -31, 1,   0,   -1};

        // Reset values
        do_reset();
        reset_n = 1'b0;
        #1;
        chk("reset up", int'(up), 0);
        chk("reset dwn", int'(dwn), 0);
        chk("reset err", int'(err), 0);
        chk("reset err_valid", int'(err_valid), 0);
        chk("reset slip", int'(slip), 0);
        chk("reset locked", int'(locked), 0);

        // Table-driven steady-state patterns
        foreach (vecs[i]) begin
            do_reset();
            nstr = 0; nup = 0; ndwn = 0; nstray = 0;
            len = ((vecs[i].ref_off > vecs[i].fb_off) ? vecs[i].ref_off : vecs[i].fb_off)
                  + vecs[i].n * vecs[i].per + 50;
            for (int c = 0; c < len; c++) begin
                r = (vecs[i].pre && pre_ref(c)) ||
                    (vecs[i].ref_en && wave(c, vecs[i].ref_off, vecs[i].per, vecs[i].n));
                f = (vecs[i].pre && pre_fb(c)) ||
                    (vecs[i].fb_en && wave(c, vecs[i].fb_off, vecs[i].per, vecs[i].n));
                tick(r, f);
                if (c >= 16) begin
                    if (up) nup++;
                    if (dwn) ndwn++;
                    if (slip && !err_valid) nstray++;
                    if (err_valid) begin
                        nstr++;
                        got = $signed(err);
                        chk($sformatf("v%0d strobe%0d err", i, nstr), got, vecs[i].exp_err);
                        chk($sformatf("v%0d strobe%0d slip", i, nstr), int'(slip), int'(vecs[i].exp_slip));
                    end
                end
            end
            chk($sformatf("v%0d strobe count", i), nstr, vecs[i].exp_n);
            chk($sformatf("v%0d stray slip", i), nstray, 0);
            chk($sformatf("v%0d locked", i), int'(locked), 0);
            if (vecs[i].exp_up >= 0) chk($sformatf("v%0d up cycles", i), nup, vecs[i].exp_up);
            if (vecs[i].exp_dwn >= 0) chk($sformatf("v%0d dwn cycles", i), ndwn, vecs[i].exp_dwn);
            if (vecs[i].exp_n == 0) chk($sformatf("v%0d err held", i), int'(err), 0);
        end

        // Lock acquisition on identical edges, then loss on a +3 offset
        do_reset();
        nstr = 0; seen16 = 0; nlock = 0;
        for (int c = 0; c < 720; c++) begin
            r = pre_ref(c) || wave(c, 20, 40, 17);
            f = pre_fb(c) || wave(c, 20, 40, 16) || wave(c, 663, 40, 1);
            tick(r, f);
            if (seen16) begin
                chk("lock rises after 16th strobe", int'(locked), 1);
                seen16 = 0;
            end
            if (c >= 16 && locked) nlock++;
            if (c >= 16 && err_valid) begin
                nstr++;
                got = $signed(err);
                if (nstr <= 16) begin
                    chk($sformatf("lock strobe%0d err", nstr), got, 0);
                    chk($sformatf("lock strobe%0d locked", nstr), int'(locked), 0);
                    if (nstr == 16) seen16 = 1;
                end else begin
                    chk("offset strobe err", got, 3);
                    chk("offset strobe locked", int'(locked), 0);
                end
            end
        end
        chk("lock strobe count", nstr, 17);
        chk("locked cycles", nlock > 0 ? 1 : 0, 1);
        chk("locked after offset", int'(locked), 0);

        // Asynchronous reset in the middle of a LEAD measurement (cnt=9)
        do_reset();
        uprun = 0;
        for (int c = 0; c < 60 && uprun < 9; c++) begin
            tick(pre_ref(c) || ((c >= 20) && (c < 28)), pre_fb(c));
            if (c >= 16 && up) uprun++;
        end
        chk("mid-lead up cycles before reset", uprun, 9);
        chk("err before reset", int'(err), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset up", int'(up), 0);
        chk("async reset err", int'(err), 0);
        chk("async reset flags", int'({dwn, err_valid, slip, locked}), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        nstr = 0; nup = 0; got = 0;
        for (int c = 0; c < 80; c++) begin
            tick((c >= 40) && (c < 48), ((c >= 10) && (c < 18)) || ((c >= 44) && (c < 52)));
            if (up || dwn) nup++;
            if (err_valid) begin
                nstr++;
                got = $signed(err);
                if (c < 40) chk("strobe before re-arm", c, 40);
            end
        end
        chk("post-reset strobe count", nstr, 1);
        chk("post-reset err", got, 4);
        chk("post-reset up/dwn cycles", nup, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_pfd_lock.md
# tdc_pfd_lock

Parametrised sequential phase-frequency detector and time-to-digital converter for the ADPLL loop. Samples the reference and feedback clocks in the system `clk` domain, measures each ref/fb edge separation as a saturating count of `clk` cycles, and emits a signed binary phase error with a valid strobe. Adds cycle-slip detection and a lock detector. Feeds the digital loop filter directly; no thermometer-to-binary stage is needed downstream.

## Interface
- `CNT_W`, 5: count width; max magnitude `MAX = 2**CNT_W - 1`
- `SYNC_STAGES`, 2: synchroniser flops per async input (>= 2)
- `LOCK_TOL`, 1: max |error| counted as in-lock
- `LOCK_CNT`, 16: consecutive in-tolerance measurements needed to assert `locked`
- `clk` input 1: system sampling clock; all logic on rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `clk_ref` input 1: reference clock, asynchronous to `clk`
- `fb_clk` input 1: DCO feedback clock, asynchronous to `clk`
- `up` output 1: high while in state LEAD
- `dwn` output 1: high while in state LAG
- `err` output CNT_W+1: signed two's-complement phase error; positive means ref leads
- `err_valid` output 1: one-cycle strobe, new `err` value
- `slip` output 1: one-cycle strobe, cycle slip detected
- `locked` output 1: lock indicator

## Operation
- Each async input passes through `SYNC_STAGES` flops and then one edge-detect flop.
  - `ref_rise = s_ref & ~s_ref_d`; `fb_rise` is formed the same way.
- Arming: `armed` clears on reset and sets on the first `ref_rise`.
  - While unarmed, `fb_rise` is ignored.
  - The arming `ref_rise` itself is processed normally.
- FSM states are IDLE, LEAD and LAG. `cnt` is CNT_W bits. Increments saturate at MAX.
- IDLE:
  - `ref_rise & fb_rise`: emit err=0, stay IDLE.
  - `ref_rise` only: go to LEAD, `cnt<=1`.
  - `fb_rise` only (armed): go to LAG, `cnt<=1`.
- LEAD:
  - `fb_rise & ~ref_rise`: emit `err=+cnt`, go to IDLE.
  - `ref_rise & ~fb_rise`: slip. Emit `err=+MAX`, pulse `slip`, stay LEAD, `cnt<=1`.
  - `ref_rise & fb_rise`: emit `err=+cnt`, stay LEAD, `cnt<=1` (the new ref edge starts a new measurement).
  - No edge: `cnt<=sat(cnt+1)`.
- LAG: mirror of LEAD with ref and fb swapped. Emitted values are `-cnt` and `-MAX`.
- `err` holds its last emitted value between strobes.
- Lock detector, updated on each `err_valid`:
  - If `|err| <= LOCK_TOL`, `lock_cnt<=sat(lock_cnt+1)`; otherwise `lock_cnt<=0`.
  - `locked` sets when `lock_cnt` reaches `LOCK_CNT`.
  - `locked` clears in the same cycle that an out-of-tolerance `err_valid` or a `slip` is registered. Clearing also zeroes `lock_cnt`.
  - `lock_cnt` width is `$clog2(LOCK_CNT+1)`.
- Reset mid-measurement: all state is abandoned immediately, with no strobe. The block is re-armed by the next `ref_rise`.

## Timing
- Reset values: `up=0`, `dwn=0`, `err=0`, `err_valid=0`, `slip=0`, `locked=0`. Internal state: IDLE, `cnt=0`, `armed=0`, all sync flops 0.
- Input pin edge to `ref_rise`/`fb_rise` asserted: `SYNC_STAGES+1` `clk` cycles, ±1 cycle of sampling uncertainty.
- `err`, `err_valid`, `slip`, `up`, `dwn` are registered and update one cycle after the cycle in which the edge is detected.
- Measurement: `ref_rise` in cycle t and `fb_rise` in cycle t+k give `err=+k`, saturated at MAX.
  - k=0 gives `err=0`.
  - k >= MAX gives `err=+MAX` with no `slip`.
- `locked` rises on the cycle after the `LOCK_CNT`-th consecutive in-tolerance `err_valid`.
- Resolution is one `clk` period. Both input clocks must be slower than `clk/2` after synchronisation; faster inputs are outside spec.

## Test plan
All scenarios use CNT_W=5, SYNC_STAGES=2, LOCK_TOL=1, LOCK_CNT=16.
- Reset, then fb_clk toggling with no ref edge -> `err_valid` never asserts; all outputs stay 0.
- ref rising edge leads fb rising edge by 7 `clk` periods, period 64 -> `err_valid` strobes with `err=+7`; `up` is high for 7 cycles; `dwn=0`.
- fb leads ref by 12 cycles -> `err=-12` (6'b110100); `dwn` is high for 12 cycles.
- ref and fb driven by identical edges -> `err=0` every period. `locked` rises after the 16th strobe, then falls on the first injected 3-cycle offset (`err=+3`).
- fb stopped while ref continues, ref period 80 -> first strobe `err=+31` with `slip=1`; `slip` repeats every ref edge; `locked=0`.
- Assert `reset_n=0` mid-LEAD with `cnt=9` -> outputs and FSM return to reset values asynchronously. After release, no strobe occurs until the next ref/fb pair.
